// File: rtl/search_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : search_pkg
//  Brief    : Shared types and constants for the search loader.
//  Revision : 1.0 - initial release
// ============================================================================
package search_pkg;

    localparam int LETTER_W_DEF = 3;

    // All-ones letter code terminates the sequence memory.
    localparam logic [LETTER_W_DEF-1:0] END_SYM = {LETTER_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_PAT  = 3'd1,
        LOAD_SEQ  = 3'd2,
        TERM      = 3'd3,
        START     = 3'd4,
        WAIT_CLR  = 3'd5,
        WAIT_DONE = 3'd6
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/ld_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ld_counter
//  Brief    : Up-counter with clear, enable and saturation at MAX.
//             Clear and enable together restart the count at 1.
//  Revision : 1.0 - initial release
// ============================================================================
module ld_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, enable increments until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? WIDTH'(1) : '0;
        end else if (en && !sat) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == WIDTH'(MAX));

endmodule
`default_nettype wire

// File: rtl/search_loader.sv
`default_nettype none
// ============================================================================
//  Module   : search_loader
//  Brief    : Loads pattern and sequence memories of the searcher from a host
//             letter stream, terminates the sequence with END_SYM, starts the
//             search and captures its result.
//             Optional macro SEARCH_LOADER_TIMEOUT_EN adds a wait watchdog
//             and the sticky 'timeout' output.
//  Revision : 1.0 - initial release
// ============================================================================
module search_loader
    import search_pkg::*;
#(
    parameter int LETTER_W = LETTER_W_DEF,
    parameter int MAX_PAT  = 8,
    parameter int MAX_SEQ  = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                         clock,
    input  logic                         reset_N,
    input  logic                         in_valid,
    input  logic [LETTER_W-1:0]          in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         pat_we,
    output logic [$clog2(MAX_PAT)-1:0]   pat_addr,
    output logic [LETTER_W-1:0]          pat_wdata,
    output logic                         seq_we,
    output logic [$clog2(MAX_SEQ)-1:0]   seq_addr,
    output logic [LETTER_W-1:0]          seq_wdata,
    output logic [$clog2(MAX_PAT):0]     pat_len,
    output logic                         ready,
    input  logic                         done,
    input  logic                         found_it,
    input  logic                         error,
    output logic                         busy,
    output logic                         result_valid,
    output logic                         result_found,
    output logic                         result_err,
`ifdef SEARCH_LOADER_TIMEOUT_EN
    output logic                         timeout,
`endif
    output logic                         load_err
);

    localparam int PA_W = $clog2(MAX_PAT);
    localparam int PC_W = $clog2(MAX_PAT) + 1;
    localparam int SA_W = $clog2(MAX_SEQ);
    localparam logic [LETTER_W-1:0] END_CODE = {LETTER_W{1'b1}};

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("search_loader: TIMEOUT must be at least 2");
    end

    loader_state_t   state_q, state_d;
    logic [PC_W-1:0] pat_len_q, pat_len_d;
    logic            load_err_q, load_err_d;
    logic            res_valid_q, res_valid_d;
    logic            res_found_q, res_found_d;
    logic            res_err_q, res_err_d;

    logic [PC_W-1:0] pcnt;
    logic [SA_W-1:0] scnt;
    logic            pcnt_sat, scnt_sat;
    logic            pcnt_clr, pcnt_en, scnt_clr, scnt_en;
    logic            is_end;
    logic            wd_fire;

    assign is_end = (in_data == END_CODE);

    ld_counter #(.WIDTH(PC_W), .MAX(MAX_PAT)) u_pcnt (
        .clk(clock), .rst_n(reset_N), .clr(pcnt_clr), .en(pcnt_en),
        .cnt(pcnt), .sat(pcnt_sat)
    );

    // Saturates one short of depth so the END_SYM slot always remains.
    ld_counter #(.WIDTH(SA_W), .MAX(MAX_SEQ-1)) u_scnt (
        .clk(clock), .rst_n(reset_N), .clr(scnt_clr), .en(scnt_en),
        .cnt(scnt), .sat(scnt_sat)
    );

`ifdef SEARCH_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_sat, in_wait;
    logic            timeout_q, timeout_d;

    assign in_wait = (state_q == WAIT_CLR) || (state_q == WAIT_DONE);

    // Fires on the TIMEOUT-th cycle spent waiting on the searcher.
    ld_counter #(.WIDTH(WD_W), .MAX(TIMEOUT-1)) u_wd (
        .clk(clock), .rst_n(reset_N), .clr(!in_wait), .en(in_wait),
        .cnt(wd_cnt), .sat(wd_sat)
    );
    assign wd_fire = in_wait && wd_sat;
    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
`endif

    // Next-state, memory strobes and result capture.
    always_comb begin
        state_d     = state_q;
        pat_len_d   = pat_len_q;
        load_err_d  = load_err_q;
        res_valid_d = 1'b0;
        res_found_d = res_found_q;
        res_err_d   = res_err_q;
        in_ready    = 1'b0;
        pat_we      = 1'b0;
        pat_addr    = pcnt[PA_W-1:0];
        pat_wdata   = in_data;
        seq_we      = 1'b0;
        seq_addr    = scnt;
        seq_wdata   = in_data;
        ready       = 1'b0;
        pcnt_clr    = 1'b0;
        pcnt_en     = 1'b0;
        scnt_clr    = 1'b0;
        scnt_en     = 1'b0;
`ifdef SEARCH_LOADER_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                pat_addr = '0;
                pcnt_clr = 1'b1;
                scnt_clr = 1'b1;
                if (in_valid) begin
                    if (is_end) begin
                        load_err_d = 1'b1;
                    end else begin
                        load_err_d = 1'b0;
                        pat_we     = 1'b1;
                        pcnt_en    = 1'b1;
                        if (in_last) begin
                            pat_len_d = PC_W'(1);
                            state_d   = LOAD_SEQ;
                        end else begin
                            state_d   = LOAD_PAT;
                        end
                    end
                end
            end
            LOAD_PAT: begin
                in_ready = 1'b1;
                scnt_clr = 1'b1;
                if (in_valid) begin
                    if (is_end || pcnt_sat) begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        pat_we  = 1'b1;
                        pcnt_en = 1'b1;
                        if (in_last) begin
                            pat_len_d = pcnt + PC_W'(1);
                            state_d   = LOAD_SEQ;
                        end
                    end
                end
            end
            LOAD_SEQ: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_end || scnt_sat) begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        seq_we  = 1'b1;
                        scnt_en = 1'b1;
                        if (in_last) state_d = TERM;
                    end
                end
            end
            TERM: begin
                seq_we    = 1'b1;
                seq_wdata = END_CODE;
                state_d   = START;
            end
            START: begin
                ready   = 1'b1;
`ifdef SEARCH_LOADER_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (wd_fire) begin
                    res_found_d = 1'b0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
`ifdef SEARCH_LOADER_TIMEOUT_EN
                    timeout_d   = 1'b1;
`endif
                    state_d     = IDLE;
                end else if (!done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    res_found_d = found_it;
                    res_err_d   = error;
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (wd_fire) begin
                    res_found_d = 1'b0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
`ifdef SEARCH_LOADER_TIMEOUT_EN
                    timeout_d   = 1'b1;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and host-visible result registers.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= IDLE;
            pat_len_q   <= '0;
            load_err_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_err_q   <= 1'b0;
`ifdef SEARCH_LOADER_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pat_len_q   <= pat_len_d;
            load_err_q  <= load_err_d;
            res_valid_q <= res_valid_d;
            res_found_q <= res_found_d;
            res_err_q   <= res_err_d;
`ifdef SEARCH_LOADER_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign busy         = (state_q != IDLE);
    assign pat_len      = pat_len_q;
    assign load_err     = load_err_q;
    assign result_valid = res_valid_q;
    assign result_found = res_found_q;
    assign result_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_search_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_search_loader
//  Brief    : Directed self-checking bench for search_loader (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_search_loader;
    import search_pkg::*;

    logic       clk = 1'b0;
    logic       reset_N;
    logic       in_valid, in_last, in_ready;
    logic [2:0] in_data;
    logic       pat_we, seq_we;
    logic [2:0] pat_addr, pat_wdata, seq_wdata;
    logic [4:0] seq_addr;
    logic [3:0] pat_len;
    logic       ready, done, found_it, error, busy;
    logic       result_valid, result_found, result_err, load_err;
`ifdef SEARCH_LOADER_TIMEOUT_EN
    logic       timeout;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    search_loader dut (
        .clock(clk), .reset_N(reset_N),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata),
        .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
        .pat_len(pat_len), .ready(ready), .done(done), .found_it(found_it), .error(error),
        .busy(busy), .result_valid(result_valid), .result_found(result_found),
        .result_err(result_err),
`ifdef SEARCH_LOADER_TIMEOUT_EN
        .timeout(timeout),
`endif
        .load_err(load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one letter for one cycle; check strobes mid-cycle, then commit.
    task automatic put(input logic [2:0] d, input bit last, input bit exp_pw,
                       input bit exp_sw, input int exp_addr, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_pwe"}, pat_we, exp_pw);
        chk({tag, "_swe"}, seq_we, exp_sw);
        if (exp_pw) begin
            chk({tag, "_paddr"}, pat_addr, exp_addr);
            chk({tag, "_pdata"}, pat_wdata, d);
        end
        if (exp_sw) begin
            chk({tag, "_saddr"}, seq_addr, exp_addr);
            chk({tag, "_sdata"}, seq_wdata, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        reset_N = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        done = 1'b0; found_it = 1'b0; error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_pwe", pat_we, 0);
        chk("rst_swe", seq_we, 0);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_rfound", result_found, 0);
        chk("rst_rerr", result_err, 0);
        chk("rst_lerr", load_err, 0);
        chk("rst_plen", pat_len, 0);
        reset_N = 1'b1;
        align();
        chk("idle_in_ready", in_ready, 1);

        // Pattern 1,2 / sequence 3,1,2, found after 10 cycles.
        put(3'd1, 0, 1, 0, 0, "t1_p0");
        put(3'd2, 1, 1, 0, 1, "t1_p1");
        put(3'd3, 0, 0, 1, 0, "t1_s0");
        put(3'd1, 0, 0, 1, 1, "t1_s1");
        put(3'd2, 1, 0, 1, 2, "t1_s2");
        @(negedge clk);
        chk("t1_term_swe", seq_we, 1);
        chk("t1_term_addr", seq_addr, 3);
        chk("t1_term_data", seq_wdata, 7);
        chk("t1_term_ready", ready, 0);
        chk("t1_term_inrdy", in_ready, 0);
        chk("t1_plen", pat_len, 2);
        @(negedge clk);
        chk("t1_start_ready", ready, 1);
        chk("t1_start_swe", seq_we, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_wait_ready", ready, 0);
            chk("t1_wait_rvalid", result_valid, 0);
            chk("t1_wait_busy", busy, 1);
        end
        align();
        done = 1'b1; found_it = 1'b1; error = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b0; found_it = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", result_valid, 1);
        chk("t1_rfound", result_found, 1);
        chk("t1_rerr", result_err, 0);
        chk("t1_idle_busy", busy, 0);
        @(negedge clk);
        chk("t1_rvalid_pulse", result_valid, 0);
        chk("t1_rfound_hold", result_found, 1);

        // done still high from the previous search must not be captured.
        align();
        done = 1'b1; found_it = 1'b0; error = 1'b1;
        put(3'd4, 1, 1, 0, 0, "t2_p0");
        put(3'd5, 1, 0, 1, 0, "t2_s0");
        @(negedge clk);
        chk("t2_plen", pat_len, 1);
        @(negedge clk);
        chk("t2_start_ready", ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stale_rvalid", result_valid, 0);
            chk("t2_stale_busy", busy, 1);
        end
        align();
        done = 1'b0;
        align();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0; error = 1'b0;
        @(negedge clk);
        chk("t2_rvalid", result_valid, 1);
        chk("t2_rfound", result_found, 0);
        chk("t2_rerr", result_err, 1);

        // Pattern overflow: ninth letter without in_last.
        align();
        for (int i = 0; i < 8; i++) put(3'(i % 7), 0, 1, 0, i, "t3_p");
        put(3'd3, 0, 0, 0, 0, "t3_ovf");
        @(negedge clk);
        chk("t3_lerr", load_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_inrdy", in_ready, 1);

        // END_SYM mid-sequence.
        align();
        put(3'd1, 1, 1, 0, 0, "t4_p0");
        @(negedge clk);
        chk("t4_lerr_clr", load_err, 0);
        align();
        put(3'd2, 0, 0, 1, 0, "t4_s0");
        put(3'd3, 0, 0, 1, 1, "t4_s1");
        put(3'd7, 0, 0, 0, 0, "t4_end");
        @(negedge clk);
        chk("t4_lerr", load_err, 1);
        chk("t4_busy", busy, 0);

        // Sequence fills all but the END_SYM slot, then overflows.
        align();
        put(3'd6, 1, 1, 0, 0, "t6_p0");
        for (int i = 0; i < 31; i++) put(3'(i % 7), 0, 0, 1, i, "t6_s");
        put(3'd2, 0, 0, 0, 0, "t6_ovf");
        @(negedge clk);
        chk("t6_lerr", load_err, 1);
        chk("t6_busy", busy, 0);

        // Asynchronous reset while waiting for done.
        align();
        put(3'd1, 1, 1, 0, 0, "t5_p0");
        put(3'd2, 1, 0, 1, 0, "t5_s0");
        align();
        align();
        align();
        chk("t5_pre_busy", busy, 1);
        #3;
        reset_N = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_ready", ready, 0);
        chk("t5_rerr", result_err, 0);
        chk("t5_rfound", result_found, 0);
        chk("t5_rvalid", result_valid, 0);
        chk("t5_lerr", load_err, 0);
        chk("t5_plen", pat_len, 0);
        @(negedge clk);
        reset_N = 1'b1;
        align();
        put(3'd3, 0, 1, 0, 0, "t5_reload");
        @(negedge clk);
        chk("t5_reload_busy", busy, 1);
        chk("t5_reload_inrdy", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
